// File: rtl/sm_trace_uart_tx.sv
// sm_trace_uart_tx: on-chip CPU execution-trace transmitter.
// Captures {pc, instr} from the fetch stage into a small FIFO and sends each
// record as a 9-byte UART 8N1 frame: SYNC_BYTE, pc[7:0..31:24], instr[7:0..31:24].
// Ports:
//   clk         CPU clock, all logic on the rising edge
//   rst_n       synchronous active-low reset
//   trace_en    global capture enable
//   trace_valid fetch-stage pc/instr valid this cycle
//   freeze      pipeline freeze, suppresses capture
//   pc, instr   fetch-stage pc and instruction (32 bits each)
//   txd         UART serial output, idle high
//   tx_busy     frame in flight or FIFO non-empty
//   fifo_full   FIFO holds 2**FIFO_DEPTH_LOG2 records
//   drop_cnt    records lost to overflow, saturating at 255
`timescale 1ns/1ps
module sm_trace_uart_tx #(
   parameter int unsigned CLK_DIV         = 16,
   parameter int unsigned FIFO_DEPTH_LOG2 = 3,
   parameter logic [7:0]  SYNC_BYTE       = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trace_en,
   input  logic        trace_valid,
   input  logic        freeze,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        txd,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_LOG2;
   localparam int unsigned PW        = FIFO_DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Full when the pointers address the same slot but sit on different laps.
   function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
      return (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
   endfunction

   logic [63:0]   fifo_mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic          empty_s, full_s, cap_s, push_s, pop_s, drop_s;
   tx_state_t     state_r, state_s;
   logic [15:0]   baud_cnt_r, baud_cnt_s;
   logic [2:0]    bit_idx_r, bit_idx_s;
   logic [3:0]    byte_idx_r, byte_idx_s;
   logic [63:0]   frame_r;
   logic [2:0]    byte_sel_s;
   logic [7:0]    cur_byte_s;
   logic          baud_tick_s, txd_s;
   logic          txd_r, tx_busy_r, fifo_full_r;
   logic [7:0]    drop_cnt_r;

   // Capture qualification and FIFO push/pop/drop decisions.
   always_comb begin
      cap_s    = trace_en & trace_valid & ~freeze;
      empty_s  = (wr_ptr_r == rd_ptr_r);
      full_s   = ptr_full(wr_ptr_r, rd_ptr_r);
      pop_s    = (state_r == ST_IDLE) & ~empty_s;
      // A pop on the same edge frees the slot the push needs.
      push_s   = cap_s & (~full_s | pop_s);
      drop_s   = cap_s & full_s & ~pop_s;
      wr_ptr_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
   end

   // Record storage; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[PW-2:0]] <= {instr, pc};
      end
   end

   // Baud tick and the byte currently on the line (byte 0 is the sync byte).
   always_comb begin
      baud_tick_s = (baud_cnt_r == BAUD_LAST);
      byte_sel_s  = byte_idx_r[2:0] - 3'd1;
      if (byte_idx_r == 4'd0) begin
         cur_byte_s = SYNC_BYTE;
      end else begin
         cur_byte_s = frame_r[{byte_sel_s, 3'b000} +: 8];
      end
   end

   // Sequencer next-state and bit/byte/baud counter updates.
   always_comb begin
      state_s    = state_r;
      baud_cnt_s = baud_cnt_r;
      bit_idx_s  = bit_idx_r;
      byte_idx_s = byte_idx_r;
      case (state_r)
         ST_IDLE: begin
            baud_cnt_s = 16'd0;
            bit_idx_s  = 3'd0;
            if (pop_s) begin
               state_s    = ST_START;
               byte_idx_s = 4'd0;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_START: begin
            if (baud_tick_s) begin
               state_s    = ST_DATA;
               baud_cnt_s = 16'd0;
               bit_idx_s  = 3'd0;
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_tick_s) begin
               baud_cnt_s = 16'd0;
               if (bit_idx_r == 3'd7) begin
                  state_s = ST_STOP;
               end else begin
                  bit_idx_s = bit_idx_r + 3'd1;
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_tick_s) begin
               baud_cnt_s = 16'd0;
               if (byte_idx_r == 4'd8) begin
                  state_s = ST_IDLE;
               end else begin
                  // Next byte's start bit follows the stop bit with no gap.
                  byte_idx_s = byte_idx_r + 4'd1;
                  state_s    = ST_START;
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            baud_cnt_s = 16'd0;
            bit_idx_s  = 3'd0;
            byte_idx_s = 4'd0;
         end
      endcase
   end

   // Line level for the current sequencer state (registered one cycle later).
   always_comb begin
      case (state_r)
         ST_IDLE:  txd_s = 1'b1;
         ST_START: txd_s = 1'b0;
         ST_DATA:  txd_s = cur_byte_s[bit_idx_r];
         ST_STOP:  txd_s = 1'b1;
         default:  txd_s = 1'b1;
      endcase
   end

   // State, pointers, frame register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         baud_cnt_r  <= 16'd0;
         bit_idx_r   <= 3'd0;
         byte_idx_r  <= 4'd0;
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         frame_r     <= 64'd0;
         txd_r       <= 1'b1;
         tx_busy_r   <= 1'b0;
         fifo_full_r <= 1'b0;
         drop_cnt_r  <= 8'd0;
      end else begin
         state_r     <= state_s;
         baud_cnt_r  <= baud_cnt_s;
         bit_idx_r   <= bit_idx_s;
         byte_idx_r  <= byte_idx_s;
         wr_ptr_r    <= wr_ptr_s;
         rd_ptr_r    <= rd_ptr_s;
         txd_r       <= txd_s;
         tx_busy_r   <= (state_r != ST_IDLE) | ~empty_s;
         fifo_full_r <= ptr_full(wr_ptr_s, rd_ptr_s);
         if (pop_s) begin
            frame_r <= fifo_mem_r[rd_ptr_r[PW-2:0]];
         end else begin
            frame_r <= frame_r;
         end
         if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end else begin
            drop_cnt_r <= drop_cnt_r;
         end
      end
   end

   assign txd       = txd_r;
   assign tx_busy   = tx_busy_r;
   assign fifo_full = fifo_full_r;
   assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_sm_trace_uart_tx.sv
`timescale 1ns/1ps
module tb_sm_trace_uart_tx;

   localparam int CLK_DIV   = 4;
   localparam int BYTE_CYC  = 10 * CLK_DIV;
   localparam int FRAME_CYC = 90 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trace_en = 1'b0;
   logic        trace_valid = 1'b0;
   logic        freeze = 1'b0;
   logic [31:0] pc = 32'd0;
   logic [31:0] instr = 32'd0;
   logic        txd, tx_busy, fifo_full;
   logic [7:0]  drop_cnt;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // receiver output and scoreboard
   logic [7:0]  rx_q[$];
   int          rx_t[$];
   int          rx_ferr = 0;
   logic [63:0] exp_q[$];
   logic [7:0]  fr_b[9];
   int          fr_t[9];

   sm_trace_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_LOG2(3), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .trace_valid(trace_valid),
      .freeze(freeze), .pc(pc), .instr(instr), .txd(txd), .tx_busy(tx_busy),
      .fifo_full(fifo_full), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART receiver model: samples mid-bit on falling edges.
   logic [7:0] rx_byte;
   int         rx_t0;
   logic       rx_glitch;
   always begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
         rx_t0 = cyc;
         rx_glitch = 1'b0;
         repeat (CLK_DIV / 2) @(negedge clk);
         if (txd !== 1'b0) rx_glitch = 1'b1;
         for (int b = 0; b < 8; b++) begin
            repeat (CLK_DIV) @(negedge clk);
            rx_byte[b] = txd;
         end
         repeat (CLK_DIV) @(negedge clk);
         if (txd !== 1'b1 || rx_glitch) rx_ferr++;
         rx_q.push_back(rx_byte);
         rx_t.push_back(rx_t0);
         repeat (CLK_DIV / 2 - 1) @(negedge clk);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      trace_valid = 1'b0;
      freeze = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic flush_rx();
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
      rx_ferr = 0;
   endtask

   task automatic wait_frame(output bit got);
      int waited = 0;
      while (rx_q.size() < 9 && waited < 3 * FRAME_CYC) begin
         @(negedge clk);
         waited++;
      end
      got = (rx_q.size() >= 9);
      for (int i = 0; i < 9; i++) begin
         fr_b[i] = got ? rx_q.pop_front() : 8'h00;
         fr_t[i] = got ? rx_t.pop_front() : 0;
      end
   endtask

   task automatic wait_until(input int target);
      int guard = 0;
      while (cyc < target && guard < 10000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   function automatic logic [63:0] frame_rec();
      return {fr_b[4], fr_b[3], fr_b[2], fr_b[1], fr_b[8], fr_b[7], fr_b[6], fr_b[5]};
   endfunction

   task automatic test_reset();
      int bad = 0;
      do_reset(4);
      tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b expected 1", txd); end
      tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
      tests_run++; if (fifo_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
      tests_run++; if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
      trace_en = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL idle_line: got %0d non-idle cycles expected 0", bad); end
   endtask

   task automatic test_single();
      int n;
      bit got;
      logic [71:0] all_b;
      @(negedge clk);
      trace_en = 1'b1; trace_valid = 1'b1; pc = 32'h0000_0010; instr = 32'h0050_0513;
      n = cyc + 1;
      exp_q.push_back({pc, instr});
      @(negedge clk);
      trace_valid = 1'b0;
      wait_frame(got);
      tests_run++; if (!got) begin tests_failed++; $display("FAIL single_timeout: got no frame expected one"); end
      tests_run++; if (fr_t[0] != n + 2) begin tests_failed++; $display("FAIL single_latency: got start cycle %0d expected %0d", fr_t[0], n + 2); end
      all_b = {fr_b[0], fr_b[1], fr_b[2], fr_b[3], fr_b[4], fr_b[5], fr_b[6], fr_b[7], fr_b[8]};
      tests_run++; if (all_b !== 72'hA5_10_00_00_00_13_05_50_00) begin tests_failed++; $display("FAIL single_bytes: got %h expected a51000000013055000", all_b); end
      tests_run++; if (frame_rec() !== exp_q.pop_front()) begin tests_failed++; $display("FAIL single_scoreboard: got %h", frame_rec()); end
      tests_run++; if (fr_t[8] - fr_t[0] + BYTE_CYC != FRAME_CYC) begin tests_failed++; $display("FAIL single_duration: got %0d expected %0d", fr_t[8] - fr_t[0] + BYTE_CYC, FRAME_CYC); end
      wait_until(fr_t[8] + BYTE_CYC - 1);
      tests_run++; if (tx_busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_stop: got %b expected 1", tx_busy); end
      @(negedge clk);
      tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end: got %b expected 0", tx_busy); end
      tests_run++; if (rx_ferr != 0) begin tests_failed++; $display("FAIL single_framing: got %0d errors expected 0", rx_ferr); end
   endtask

   task automatic test_freeze();
      bit got;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         trace_valid = 1'b1; freeze = 1'b1; pc = 32'h100 + 32'(4 * i); instr = 32'h0000_0013;
      end
      @(negedge clk);
      freeze = 1'b0; pc = 32'h0000_0200; instr = 32'h00A0_0093;
      exp_q.push_back({pc, instr});
      @(negedge clk);
      trace_valid = 1'b0;
      wait_frame(got);
      tests_run++; if (!got) begin tests_failed++; $display("FAIL freeze_timeout: got no frame expected one"); end
      tests_run++; if (fr_b[0] !== 8'hA5) begin tests_failed++; $display("FAIL freeze_sync: got %h expected a5", fr_b[0]); end
      tests_run++; if (frame_rec() !== 64'h0000_0200_00A0_0093) begin tests_failed++; $display("FAIL freeze_record: got %h expected 0000020000a00093", frame_rec()); end
      void'(exp_q.pop_front());
      repeat (100) @(negedge clk);
      tests_run++; if (rx_q.size() != 0) begin tests_failed++; $display("FAIL freeze_extra: got %0d extra bytes expected 0", rx_q.size()); end
      tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL freeze_busy: got %b expected 0", tx_busy); end
   endtask

   task automatic test_overflow();
      bit got;
      int prev = 0;
      logic [63:0] e;
      do_reset(2);
      flush_rx();
      trace_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 8) begin
            tests_run++; if (fifo_full !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_8: got %b expected 0", fifo_full); end
         end
         if (i == 9) begin
            tests_run++; if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full_9: got %b expected 1", fifo_full); end
         end
         trace_valid = 1'b1; pc = 32'(4 * i); instr = 32'h0000_0013 | 32'(i << 20);
         if (i < 9) exp_q.push_back({pc, instr});
      end
      @(negedge clk);
      trace_valid = 1'b0;
      tests_run++; if (drop_cnt !== 8'd11) begin tests_failed++; $display("FAIL ovf_drop: got %0d expected 11", drop_cnt); end
      for (int k = 0; k < 9; k++) begin
         wait_frame(got);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
         tests_run++; if (!got || fr_b[0] !== 8'hA5 || frame_rec() !== e) begin
            tests_failed++; $display("FAIL ovf_frame%0d: got %h/%h expected a5/%h", k, fr_b[0], frame_rec(), e);
         end
         if (k > 0) begin
            tests_run++; if (fr_t[0] - prev != FRAME_CYC + 1) begin tests_failed++; $display("FAIL ovf_gap%0d: got %0d expected %0d", k, fr_t[0] - prev, FRAME_CYC + 1); end
         end
         prev = fr_t[0];
      end
      repeat (50) @(negedge clk);
      tests_run++; if (tx_busy !== 1'b0 || fifo_full !== 1'b0 || rx_q.size() != 0) begin
         tests_failed++; $display("FAIL ovf_drain: got busy=%b full=%b extra=%0d expected 0 0 0", tx_busy, fifo_full, rx_q.size());
      end
      tests_run++; if (rx_ferr != 0) begin tests_failed++; $display("FAIL ovf_framing: got %0d errors expected 0", rx_ferr); end
   endtask

   task automatic test_saturation();
      do_reset(2);
      flush_rx();
      trace_en = 1'b1;
      for (int i = 0; i < 320; i++) begin
         @(negedge clk);
         if (i == 200) begin
            tests_run++; if (drop_cnt !== 8'd191) begin tests_failed++; $display("FAIL sat_mid: got %0d expected 191", drop_cnt); end
         end
         trace_valid = 1'b1; pc = 32'(4 * i); instr = 32'h0000_0013;
      end
      @(negedge clk);
      trace_valid = 1'b0;
      tests_run++; if (drop_cnt !== 8'd255) begin tests_failed++; $display("FAIL sat_hold: got %0d expected 255", drop_cnt); end
      tests_run++; if (fifo_full !== 1'b1) begin tests_failed++; $display("FAIL sat_full: got %b expected 1", fifo_full); end
      do_reset(2);
      repeat (50) @(negedge clk);
      flush_rx();
   endtask

   task automatic test_reset_mid_frame();
      int n;
      int bad = 0;
      bit got;
      @(negedge clk);
      trace_valid = 1'b1; pc = 32'hDEAD_BEEF; instr = 32'hFFF0_0113;
      n = cyc + 1;
      @(negedge clk);
      trace_valid = 1'b0;
      wait_until(n + 2 + 3 * BYTE_CYC + CLK_DIV + 2 * CLK_DIV);
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL midrst_txd: got %b expected 1", txd); end
      tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
      rst_n = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
      flush_rx();
      @(negedge clk);
      trace_valid = 1'b1; pc = 32'h0000_1234; instr = 32'h0010_0073;
      n = cyc + 1;
      exp_q.push_back({pc, instr});
      @(negedge clk);
      trace_valid = 1'b0;
      wait_frame(got);
      tests_run++; if (!got || fr_t[0] != n + 2) begin tests_failed++; $display("FAIL midrst_restart: got start %0d expected %0d", fr_t[0], n + 2); end
      tests_run++; if (fr_b[0] !== 8'hA5 || frame_rec() !== exp_q.pop_front()) begin
         tests_failed++; $display("FAIL midrst_frame: got %h/%h expected a5/0000123400100073", fr_b[0], frame_rec());
      end
      tests_run++; if (rx_ferr != 0) begin tests_failed++; $display("FAIL midrst_framing: got %0d errors expected 0", rx_ferr); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_freeze();
      test_overflow();
      test_saturation();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
